wash_run: RTL and testbench
===========================

Name: wash_run

Overview:
- Consumer side of the pre-stage handshake in the washing-machine design.
- Once the pre-stage asserts isOn and the user presses the confirm button, the block latches the balance and mode, then deducts the mode's price.
- It then counts down the mode's wash time in 1 s ticks, with pause/resume on the right button.
- It reports done or error, and drives four BCD digits for the 4-digit scan display.

Parameters:
- TICK_CYC, 100000000, clk cycles per 1 s tick (bench uses 10).
- COST0, 10, price of mode 0.
- COST1, 20, price of mode 1.
- COST2, 30, price of mode 2.
- COST3, 50, price of mode 3.
- TIME0, 30, wash seconds for mode 0.
- TIME1, 45, wash seconds for mode 1.
- TIME2, 60, wash seconds for mode 2.
- TIME3, 90, wash seconds for mode 3.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous reset, active-high.
- isOn  in  1  pre-stage says balance/mode are valid.
- bal  in  10  balance from pre-stage, 0..999.
- mode  in  2  selected wash mode.
- bt  in  1  confirm button, raw level.
- ri_bt  in  1  pause/resume button, raw level.
- new_bal  out  10  balance after deduction.
- remain  out  10  seconds left.
- busy  out  1  high in RUN or PAUSE.
- paused  out  1  high in PAUSE.
- done  out  1  high in DONE.
- err  out  1  high in ERR.
- d3  out  4  display digit, hundreds.
- d2  out  4  display digit, tens.
- d1  out  4  display digit, units.
- d0  out  4  display digit, status.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; new_bal=0, remain=0; busy/paused/done/err=0.
  - Tick counter=0; sync flops=0.
  - rst overrides everything, including mid-RUN.
- Buttons:
  - bt and ri_bt each pass through a 2-flop synchronizer plus a previous-value flop.
  - Rising-edge pulse = sync2 & ~prev, one cycle wide.
  - A state change is visible 3 clk edges after the raw input rises.
  - Holding a button produces exactly one pulse.
- States:
  - IDLE: on bt pulse with isOn=1, latch bal→bal_l and mode→mode_l, go to CHECK. A bt pulse with isOn=0 is ignored.
  - CHECK (exactly 1 cycle): cost=COSTmode_l, time=TIMEmode_l.
    - If bal_l >= cost (equality passes): new_bal=bal_l-cost, remain=time, tick counter=0, go to RUN.
    - Otherwise: new_bal=bal_l, go to ERR.
  - RUN: tick counter increments each cycle.
    - When it reaches TICK_CYC-1, it wraps to 0 and remain decrements.
    - If remain becomes 0, go to DONE on the same edge.
    - On ri_bt pulse, go to PAUSE.
  - PAUSE: tick counter and remain hold. On ri_bt pulse, go to RUN; the count resumes from the held value.
  - DONE: done=1, remain=0. On bt pulse, go to IDLE; new_bal is retained.
  - ERR: err=1. On bt pulse, go to IDLE.
- Simultaneous events:
  - In RUN, if a tick and an ri_bt pulse land on the same cycle, the decrement applies and the state goes to PAUSE.
  - If that tick takes remain to 0, DONE wins over PAUSE.
  - bt pulses in RUN and PAUSE are ignored.
  - Changes on bal or mode after latching have no effect.
- Arithmetic:
  - All values are unsigned 10-bit.
  - Subtraction occurs only when bal_l >= cost, so there is no underflow.
  - remain never goes below 0.
- Display, combinational from registered state:
  - Displayed value: IDLE shows bal (input); RUN, PAUSE and DONE show remain; ERR shows new_bal.
  - Value >999 saturates to 999.
  - d3/d2/d1 are the BCD hundreds/tens/units of the displayed value.
  - d0 encoding: mode_l in RUN and DONE; 12 in PAUSE; 11 ("E") in ERR; 15 (blank) in IDLE.

Test Plan:
- TICK_CYC=10, bal=100, mode=1, isOn=1, pulse bt -> CHECK then RUN; new_bal=80, remain=45, d3..d1=0,4,5; after 450 cycles DONE with done=1, remain=0.
- bal=30, mode=2 (exact price) -> RUN with new_bal=0. bal=29, mode=2 -> ERR: err=1, new_bal=29, d0=11; then bt pulse -> IDLE with err=0.
- In RUN at remain=40, pulse ri_bt -> PAUSE: paused=1, remain stays 40 for 100 cycles. Pulse ri_bt again -> RUN; decrement timing continues from the held tick count.
- ri_bt pulse on the same cycle as the tick that makes remain 0 -> DONE, not PAUSE. ri_bt on a tick with remain=5 -> remain=4 and state PAUSE.
- isOn=0 with bt pulse -> stays IDLE. bt held high 50 cycles -> single transition. bt pulse during RUN -> ignored.
- Assert rst mid-RUN (remain=20) -> next cycle: IDLE, every output at its reset value, d0=15.

Source files
------------

// File: rtl/wash_run_if.sv
// Pre-stage handshake and status/display bundle for the wash_run consumer.
// The producer side drives the inputs and the run block drives the status and display outputs.
interface wash_run_if;
  logic       isOn;
  logic [9:0] bal;
  logic [1:0] mode;
  logic       bt;
  logic       ri_bt;
  logic [9:0] new_bal;
  logic [9:0] remain;
  logic       busy;
  logic       paused;
  logic       done;
  logic       err;
  logic [3:0] d3;
  logic [3:0] d2;
  logic [3:0] d1;
  logic [3:0] d0;

  modport master (
    output isOn, bal, mode, bt, ri_bt,
    input  new_bal, remain, busy, paused, done, err, d3, d2, d1, d0
  );

  modport slave (
    input  isOn, bal, mode, bt, ri_bt,
    output new_bal, remain, busy, paused, done, err, d3, d2, d1, d0
  );
endinterface

// File: rtl/wash_run.sv
// Wash cycle runner: latches balance/mode on confirm, charges the mode price, counts the
// wash time down in 1 s ticks with pause/resume, and drives a 4-digit BCD status display.
module wash_run #(
  parameter int TICK_CYC = 100000000,
  parameter int COST0    = 10,
  parameter int COST1    = 20,
  parameter int COST2    = 30,
  parameter int COST3    = 50,
  parameter int TIME0    = 30,
  parameter int TIME1    = 45,
  parameter int TIME2    = 60,
  parameter int TIME3    = 90
) (
  input logic      clk,
  input logic      rst,
  wash_run_if.slave io
);

  localparam int TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYC - 1);

  typedef enum logic [2:0] {IDLE, CHECK, RUN, PAUSE, DONE, ERR} state_e;

  state_e        state_q, state_d;
  logic [9:0]    bal_l_q, bal_l_d;
  logic [1:0]    mode_l_q, mode_l_d;
  logic [9:0]    new_bal_q, new_bal_d;
  logic [9:0]    remain_q, remain_d;
  logic [TW-1:0] tick_q, tick_d;

  logic bt_s1_q, bt_s2_q, bt_prev_q;
  logic ri_s1_q, ri_s2_q, ri_prev_q;
  logic bt_pulse, ri_pulse;

  logic [9:0] cost, wash_time;
  logic [9:0] disp_val, disp_sat;
  logic [3:0] disp_status;

  assign bt_pulse = bt_s2_q & ~bt_prev_q;
  assign ri_pulse = ri_s2_q & ~ri_prev_q;

  always_comb begin
    unique case (mode_l_q)
      2'd0:    begin cost = 10'(COST0); wash_time = 10'(TIME0); end
      2'd1:    begin cost = 10'(COST1); wash_time = 10'(TIME1); end
      2'd2:    begin cost = 10'(COST2); wash_time = 10'(TIME2); end
      default: begin cost = 10'(COST3); wash_time = 10'(TIME3); end
    endcase
  end

  // NOTE: state and synchronizer flops use <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bal_l_q   <= '0;
      mode_l_q  <= '0;
      new_bal_q <= '0;
      remain_q  <= '0;
      tick_q    <= '0;
      bt_s1_q   <= 1'b0;
      bt_s2_q   <= 1'b0;
      bt_prev_q <= 1'b0;
      ri_s1_q   <= 1'b0;
      ri_s2_q   <= 1'b0;
      ri_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bal_l_q   <= bal_l_d;
      mode_l_q  <= mode_l_d;
      new_bal_q <= new_bal_d;
      remain_q  <= remain_d;
      tick_q    <= tick_d;
      bt_s1_q   <= io.bt;
      bt_s2_q   <= bt_s1_q;
      bt_prev_q <= bt_s2_q;
      ri_s1_q   <= io.ri_bt;
      ri_s2_q   <= ri_s1_q;
      ri_prev_q <= ri_s2_q;
    end
  end

  // NOTE: every variable gets a hold default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    bal_l_d   = bal_l_q;
    mode_l_d  = mode_l_q;
    new_bal_d = new_bal_q;
    remain_d  = remain_q;
    tick_d    = tick_q;
    unique case (state_q)
      IDLE: begin
        if (bt_pulse && io.isOn) begin
          bal_l_d  = io.bal;
          mode_l_d = io.mode;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (bal_l_q >= cost) begin
          new_bal_d = bal_l_q - cost;
          remain_d  = wash_time;
          tick_d    = '0;
          state_d   = RUN;
        end else begin
          new_bal_d = bal_l_q;
          state_d   = ERR;
        end
      end
      RUN: begin
        // The final tick wins over a coincident pause request.
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (remain_q != 10'd0) remain_d = remain_q - 10'd1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
        if (tick_q == TICK_LAST && remain_q <= 10'd1) state_d = DONE;
        else if (ri_pulse)                             state_d = PAUSE;
      end
      PAUSE: begin
        if (ri_pulse) state_d = RUN;
      end
      DONE: begin
        remain_d = '0;
        if (bt_pulse) state_d = IDLE;
      end
      ERR: begin
        if (bt_pulse) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    disp_val    = io.bal;
    disp_status = 4'd15;
    unique case (state_q)
      IDLE:  begin disp_val = io.bal;    disp_status = 4'd15;         end
      CHECK: begin disp_val = bal_l_q;   disp_status = 4'd15;         end
      RUN:   begin disp_val = remain_q;  disp_status = 4'(mode_l_q);  end
      PAUSE: begin disp_val = remain_q;  disp_status = 4'd12;         end
      DONE:  begin disp_val = remain_q;  disp_status = 4'(mode_l_q);  end
      ERR:   begin disp_val = new_bal_q; disp_status = 4'd11;         end
      default: begin disp_val = io.bal;  disp_status = 4'd15;         end
    endcase
    disp_sat = (disp_val > 10'd999) ? 10'd999 : disp_val;
  end

  assign io.d3      = 4'(disp_sat / 10'd100);
  assign io.d2      = 4'((disp_sat / 10'd10) % 10'd10);
  assign io.d1      = 4'(disp_sat % 10'd10);
  assign io.d0      = disp_status;
  assign io.new_bal = new_bal_q;
  assign io.remain  = remain_q;
  assign io.busy    = (state_q == RUN) || (state_q == PAUSE);
  assign io.paused  = (state_q == PAUSE);
  assign io.done    = (state_q == DONE);
  assign io.err     = (state_q == ERR);

endmodule

// File: tb/tb_wash_run.sv
// Scoreboarded bench for wash_run: jobs push their expected output changes (edge + values)
// from a seconds-level model; a monitor pops one entry each time the status outputs change.
module tb_wash_run;
  localparam int TICK = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wash_run_if io ();

  wash_run #(.TICK_CYC(TICK)) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  int cost_t[4] = '{10, 20, 30, 50};
  int time_t[4] = '{30, 45, 60, 90};

  typedef struct {
    int          at;
    logic [39:0] snap;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic logic [15:0] digits(int v, int st);
    int s;
    s = (v > 999) ? 999 : v;
    return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10), 4'(st)};
  endfunction

  function automatic logic [39:0] mk(bit b, bit p, bit d, bit e, int nb, int rem, logic [15:0] dg);
    return {b, p, d, e, 10'(nb), 10'(rem), dg};
  endfunction

  task automatic push(int at, logic [39:0] snap);
    sb.push_back('{at, snap});
  endtask

  // Monitor: any change of the status/value outputs is one observed event.
  bit          mon_en = 1'b0;
  logic [23:0] prev;
  logic [39:0] cur;
  exp_t        got;

  always @(negedge clk) begin
    if (mon_en) begin
      cur = {io.busy, io.paused, io.done, io.err, io.new_bal, io.remain,
             io.d3, io.d2, io.d1, io.d0};
      if (cur[39:16] !== prev) begin
        prev = cur[39:16];
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got %0h want none (edge %0d)", cur, edge_cnt);
        end else begin
          got = sb.pop_front();
          check("event_edge", 64'(edge_cnt), 64'(got.at));
          check($sformatf("event_at_%0d", got.at), 64'(cur), 64'(got.snap));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_edge(int e);
    while (edge_cnt < e) step();
  endtask

  task automatic sched_bt(int at, int hold);
    fork
      begin
        goto_edge(at);
        io.bt = 1'b1;
        goto_edge(at + hold);
        io.bt = 1'b0;
      end
    join_none
  endtask

  task automatic sched_ri(int at);
    fork
      begin
        goto_edge(at);
        io.ri_bt = 1'b1;
        goto_edge(at + 2);
        io.ri_bt = 1'b0;
      end
    join_none
  endtask

  task automatic sched_inputs(int at, int b, int m);
    fork
      begin
        goto_edge(at);
        io.bal  = 10'(b);
        io.mode = 2'(m);
      end
    join_none
  endtask

  // Seconds-level model: remain = time - (cycles spent running) / TICK; pulses flip run/pause.
  task automatic model_run(int r, int m, int nb, int tme, int eff[$], int stop, output int done_e);
    int n = 0;
    int rem = tme;
    int idx = 0;
    bit held = 1'b0;
    bit pulse, tick;
    done_e = -1;
    push(r, mk(1, 0, 0, 0, nb, tme, digits(tme, m)));
    for (int e = r + 1; e < stop; e++) begin
      pulse = 1'b0;
      if (idx < eff.size() && eff[idx] == e) begin
        pulse = 1'b1;
        idx++;
      end
      if (!held) begin
        n++;
        tick = (n % TICK == 0);
        if (tick) rem--;
        if (tick && rem == 0) begin
          push(e, mk(0, 0, 1, 0, nb, 0, digits(0, m)));
          done_e = e;
          return;
        end
        if (pulse) begin
          held = 1'b1;
          push(e, mk(1, 1, 0, 0, nb, rem, digits(rem, 12)));
        end else if (tick) begin
          push(e, mk(1, 0, 0, 0, nb, rem, digits(rem, m)));
        end
      end else if (pulse) begin
        held = 1'b0;
        push(e, mk(1, 0, 0, 0, nb, rem, digits(rem, m)));
      end
    end
  endtask

  // One confirm-to-idle transaction. ri_off/rst_off are edges relative to RUN entry.
  task automatic job(int b, int m, int hold, int ri_off[$], int rst_off, bit churn);
    int e0, r, cost, tme, done_e, x, bnew, mnew, last;
    int eff[$];
    cost = cost_t[m];
    tme  = time_t[m];
    io.bal  = 10'(b);
    io.mode = 2'(m);
    io.isOn = 1'b1;
    e0 = edge_cnt + 1;
    r  = e0 + 4;
    if (b < cost) begin
      x = e0 + hold + 3 + $urandom_range(0, 10);
      push(r, mk(0, 0, 0, 1, b, 0, digits(b, 11)));
      push(x + 3, mk(0, 0, 0, 0, b, 0, digits(b, 15)));
      sched_bt(e0, hold);
      sched_bt(x, 2);
      goto_edge(x + 8);
      return;
    end
    foreach (ri_off[i]) eff.push_back(r + ri_off[i]);
    bnew = churn ? $urandom_range(0, 999) : b;
    mnew = churn ? $urandom_range(0, 3) : m;
    model_run(r, m, b - cost, tme, eff, (rst_off < 0) ? r + 100000 : r + rst_off + 1, done_e);
    sched_bt(e0, hold);
    sched_inputs(r + 1, bnew, mnew);
    sched_bt(r + 60, 3);
    last = r + 70;
    foreach (eff[i]) begin
      sched_ri(eff[i] - 3);
      if (eff[i] + 5 > last) last = eff[i] + 5;
    end
    if (rst_off >= 0) begin
      push(r + rst_off + 1, mk(0, 0, 0, 0, 0, 0, digits(bnew, 15)));
      goto_edge(r + rst_off);
      rst = 1'b1;
      goto_edge(r + rst_off + 1);
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_run", {io.busy, io.paused, io.done, io.err, io.new_bal, io.remain, io.d0},
            {4'b0, 10'd0, 10'd0, 4'd15});
      step();
      goto_edge(last);
      return;
    end
    x = done_e + $urandom_range(1, 8);
    push(x + 3, mk(0, 0, 0, 0, b - cost, 0, digits(bnew, 15)));
    sched_bt(x, 2);
    goto_edge((x + 8 > last) ? x + 8 : last);
  endtask

  initial begin
    int q[$];
    int m, b, np, t;
    rst      = 1'b1;
    io.isOn  = 1'b0;
    io.bal   = '0;
    io.mode  = '0;
    io.bt    = 1'b0;
    io.ri_bt = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy",    64'(io.busy),    64'd0);
    check("rst_paused",  64'(io.paused),  64'd0);
    check("rst_done",    64'(io.done),    64'd0);
    check("rst_err",     64'(io.err),     64'd0);
    check("rst_new_bal", 64'(io.new_bal), 64'd0);
    check("rst_remain",  64'(io.remain),  64'd0);
    check("rst_d0",      64'(io.d0),      64'd15);
    prev   = 24'd0;
    mon_en = 1'b1;

    // IDLE display follows the bal input and saturates at 999.
    step();
    io.bal = 10'd1000;
    @(negedge clk);
    check("idle_disp_sat", 64'({io.d3, io.d2, io.d1, io.d0}), 64'(digits(999, 15)));
    io.bal = 10'd507;
    @(negedge clk);
    check("idle_disp_507", 64'({io.d3, io.d2, io.d1, io.d0}), 64'(digits(507, 15)));
    step();

    // Confirm without isOn must not leave IDLE.
    io.isOn = 1'b0;
    sched_bt(edge_cnt + 1, 4);
    goto_edge(edge_cnt + 20);
    @(negedge clk);
    check("ison_low_idle", 64'({io.busy, io.err, io.done, io.d0}), 64'({3'b000, 4'd15}));
    step();

    q = {};                 job(100, 1, 50, q, -1, 1'b0);
    q = {};                 job(30, 2, 1, q, -1, 1'b1);
    q = {};                 job(29, 2, 3, q, -1, 1'b0);
    q = '{53, 153};         job(100, 1, 5, q, -1, 1'b0);
    q = '{300};             job(50, 0, 2, q, -1, 1'b0);
    q = '{260, 310};        job(50, 0, 2, q, -1, 1'b0);
    q = {};                 job(100, 1, 2, q, 255, 1'b1);

    for (int i = 0; i < 10; i++) begin
      m = $urandom_range(0, 3);
      b = ($urandom_range(0, 2) == 0) ? $urandom_range(0, cost_t[m] + 3) : $urandom_range(0, 999);
      q = {};
      np = $urandom_range(0, 2);
      t = $urandom_range(3, 150);
      for (int k = 0; k < np; k++) begin
        q.push_back(t);
        t += $urandom_range(6, 120);
        q.push_back(t);
        t += $urandom_range(6, 150);
      end
      job(b, m, $urandom_range(1, 50), q, -1, 1'b1);
    end

    repeat (10) step();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    total++;
    bad++;
    $display("FAIL timeout: got running want finished (edge %0d)", edge_cnt);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
